// File: rtl/branch_predict_pcsel.sv
// Fetch PC-select with a direct-mapped BHT of saturating counters.
// Branches predict at fetch and resolve one cycle later in execute.
module branch_predict_pcsel #(
  parameter int INDEX_BITS   = 6,
  parameter int COUNTER_BITS = 2,
  parameter int PREDICT_EN   = 1,
  parameter int PERF_BITS    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [31:0]          fetch_pc,
  input  logic [31:0]          icache_dout,
  input  logic [31:0]          ex_inst,
  input  logic                 BrEq,
  input  logic                 BrLT,
  output logic [2:0]           PCSignal,
  output logic                 pred_taken,
  output logic                 mispredict,
  output logic [PERF_BITS-1:0] branch_count,
  output logic [PERF_BITS-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CNT_INIT =
    COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_NOOP   = 7'b0000000;

  localparam logic [2:0] PC_HOLD  = 3'b000;
  localparam logic [2:0] PC_ALU   = 3'b001;
  localparam logic [2:0] PC_PLUS4 = 3'b010;
  localparam logic [2:0] PC_BIMM  = 3'b011;
  localparam logic [2:0] PC_EX4   = 3'b100;

  function automatic logic f3_ok(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  logic [COUNTER_BITS-1:0] r_bht [ENTRIES];
  logic                    r_ex_valid;
  logic                    r_ex_pred;
  logic [INDEX_BITS-1:0]   r_ex_index;
  logic [PERF_BITS-1:0]    r_branch_count;
  logic [PERF_BITS-1:0]    r_mispredict_count;

  logic [INDEX_BITS-1:0]   w_fetch_idx;
  logic [COUNTER_BITS-1:0] w_bht_rd;
  logic [COUNTER_BITS-1:0] w_bht_ex;
  logic                    w_fetch_br;
  logic                    w_ex_live;
  logic                    w_ex_branch;
  logic                    w_actual;
  logic [4:0]              w_ex_rd;
  logic                    w_ex_writer;
  logic                    w_jalr_hold;
  logic                    w_unused;

  assign w_fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign w_bht_rd    = r_bht[w_fetch_idx];
  assign w_bht_ex    = r_bht[r_ex_index];
  assign w_fetch_br  = (icache_dout[6:0] == OP_BRANCH) &&
                       f3_ok(icache_dout[14:12]);
  assign pred_taken  = (PREDICT_EN != 0) && w_fetch_br &&
                       w_bht_rd[COUNTER_BITS-1];

  // Reset cycle sees the execute slot as empty.
  assign w_ex_live   = r_ex_valid && !rst;
  assign w_ex_branch = w_ex_live && (ex_inst[6:0] == OP_BRANCH) &&
                       f3_ok(ex_inst[14:12]);

  always_comb begin
    w_actual = 1'b0;
    case (ex_inst[14:12])
      3'b000:         w_actual = BrEq;
      3'b001:         w_actual = !BrEq;
      3'b100, 3'b110: w_actual = BrLT;
      default:        w_actual = !BrLT;
    endcase
  end

  assign mispredict = w_ex_branch && (w_actual != r_ex_pred);

  assign w_ex_rd     = ex_inst[11:7];
  assign w_ex_writer = (ex_inst[6:0] != OP_BRANCH) &&
                       (ex_inst[6:0] != OP_STORE) &&
                       (ex_inst[6:0] != OP_NOOP);
  assign w_jalr_hold = (icache_dout[6:0] == OP_JALR) && w_ex_live &&
                       (w_ex_rd == icache_dout[19:15]) &&
                       (w_ex_rd != 5'd0) && w_ex_writer;

  always_comb begin
    PCSignal = PC_PLUS4;
    if (stall)                        PCSignal = PC_HOLD;
    else if (mispredict && w_actual)  PCSignal = PC_ALU;
    else if (mispredict)              PCSignal = PC_EX4;
    else if (w_jalr_hold)             PCSignal = PC_HOLD;
    else if (pred_taken)              PCSignal = PC_BIMM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CNT_INIT;
      r_ex_valid         <= 1'b0;
      r_ex_pred          <= 1'b0;
      r_ex_index         <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (!stall) begin
      r_ex_valid <= !mispredict;
      r_ex_pred  <= pred_taken && !mispredict;
      r_ex_index <= w_fetch_idx;
      if (w_ex_branch) begin
        r_branch_count <= r_branch_count + 1'b1;
        if (w_actual && (w_bht_ex != CNT_MAX))
          r_bht[r_ex_index] <= w_bht_ex + 1'b1;
        else if (!w_actual && (w_bht_ex != '0))
          r_bht[r_ex_index] <= w_bht_ex - 1'b1;
      end
      if (mispredict)
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  assign w_unused = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                      icache_dout[31:20], icache_dout[11:7],
                      ex_inst[31:15]};

endmodule

// File: tb/tb_branch_predict_pcsel.sv
// Bench for branch_predict_pcsel: directed table on a predicting instance,
// then random traffic on predicting and legacy instances vs a model.
module tb_branch_predict_pcsel;

  logic        clk = 1'b0;
  logic        rst, stall, eq, lt;
  logic [31:0] pc, fi, ei;
  logic [2:0]  pcs0, pcs1;
  logic        pred0, pred1, misp0, misp1;
  logic [31:0] bc0, bc1, mc0, mc1;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  branch_predict_pcsel #(.PREDICT_EN(1)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_pc(pc),
    .icache_dout(fi), .ex_inst(ei), .BrEq(eq), .BrLT(lt),
    .PCSignal(pcs0), .pred_taken(pred0), .mispredict(misp0),
    .branch_count(bc0), .mispredict_count(mc0));

  branch_predict_pcsel #(.PREDICT_EN(0)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_pc(pc),
    .icache_dout(fi), .ex_inst(ei), .BrEq(eq), .BrLT(lt),
    .PCSignal(pcs1), .pred_taken(pred1), .mispredict(misp1),
    .branch_count(bc1), .mispredict_count(mc1));

  // Reference model: integer counters per table slot, one set per instance.
  int          m_bht [2][64];
  bit          m_exv [2];
  bit          m_exp [2];
  int          m_exi [2];
  int unsigned m_bc  [2];
  int unsigned m_mc  [2];
  int          m_pe  [2] = '{1, 0};

  function automatic bit m_isbr(logic [31:0] i);
    return i[6:0] == 7'h63 && i[14:12] != 3'd2 && i[14:12] != 3'd3;
  endfunction

  function automatic bit m_taken(logic [31:0] i, logic e, logic l);
    case (i[14:12])
      3'd0:       return e;
      3'd1:       return !e;
      3'd4, 3'd6: return l;
      default:    return !l;
    endcase
  endfunction

  task automatic model_eval(input int k, output logic [2:0] p,
                            output bit pr, output bit mi,
                            output bit ac, output bit eb);
    int  idx;
    bit  hold, wr;
    idx  = int'((pc >> 2) % 64);
    pr   = m_pe[k] != 0 && m_isbr(fi) && m_bht[k][idx] >= 2;
    eb   = !rst && m_exv[k] && m_isbr(ei);
    ac   = m_taken(ei, eq, lt);
    mi   = eb && (ac != m_exp[k]);
    wr   = ei[6:0] != 7'h63 && ei[6:0] != 7'h23 && ei[6:0] != 7'h00;
    hold = fi[6:0] == 7'h67 && !rst && m_exv[k] &&
           ei[11:7] == fi[19:15] && ei[11:7] != 5'd0 && wr;
    if (stall)         p = 3'd0;
    else if (mi && ac) p = 3'd1;
    else if (mi)       p = 3'd4;
    else if (hold)     p = 3'd0;
    else if (pr)       p = 3'd3;
    else               p = 3'd2;
  endtask

  task automatic model_clock();
    logic [2:0] p;
    bit pr, mi, ac, eb;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, p, pr, mi, ac, eb);
      if (rst) begin
        for (int i = 0; i < 64; i++) m_bht[k][i] = 1;
        m_exv[k] = 0; m_exp[k] = 0; m_exi[k] = 0;
        m_bc[k] = 0;  m_mc[k] = 0;
      end else if (!stall) begin
        if (eb) begin
          if (ac) m_bht[k][m_exi[k]] = (m_bht[k][m_exi[k]] < 3) ?
                                        m_bht[k][m_exi[k]] + 1 : 3;
          else    m_bht[k][m_exi[k]] = (m_bht[k][m_exi[k]] > 0) ?
                                        m_bht[k][m_exi[k]] - 1 : 0;
          m_bc[k]++;
        end
        if (mi) m_mc[k]++;
        m_exv[k] = !mi;
        m_exp[k] = mi ? 1'b0 : pr;
        m_exi[k] = int'((pc >> 2) % 64);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input int k);
    logic [2:0] p;
    bit pr, mi, ac, eb;
    model_eval(k, p, pr, mi, ac, eb);
    if (k == 0) begin
      check("pcsel_m0", 32'(pcs0), 32'(p));
      check("pred_m0",  32'(pred0), 32'(pr));
      check("misp_m0",  32'(misp0), 32'(mi));
      check("bcnt_m0",  bc0, m_bc[0]);
      check("mcnt_m0",  mc0, m_mc[0]);
    end else begin
      check("pcsel_m1", 32'(pcs1), 32'(p));
      check("pred_m1",  32'(pred1), 32'(pr));
      check("misp_m1",  32'(misp1), 32'(mi));
      check("bcnt_m1",  bc1, m_bc[1]);
      check("mcnt_m1",  mc1, m_mc[1]);
    end
  endtask

  typedef struct {
    bit          rst, stall;
    logic [31:0] pc, fi, ei;
    bit          eq, lt, chk;
    logic [2:0]  pcs;
    bit          pred, misp;
    int          bc, mc;
  } tv_t;

  tv_t tbl[$];

  function automatic tv_t mk(bit r, bit s, logic [31:0] p,
                             logic [31:0] f, logic [31:0] e, bit q,
                             bit c, logic [2:0] ps, bit pr, bit mi,
                             int b, int m);
    tv_t t;
    t.rst = r; t.stall = s; t.pc = p; t.fi = f; t.ei = e;
    t.eq = q; t.lt = 1'b0; t.chk = c; t.pcs = ps;
    t.pred = pr; t.misp = mi; t.bc = b; t.mc = m;
    return t;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [4:0] x;
    logic [2:0] f3;
    x  = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0, 1:    return {7'd0, 5'd2, x, f3, 5'($urandom_range(0, 7)), 7'h63};
      2:       return {12'd0, x, 3'd0, 5'd0, 7'h67};
      3:       return {12'd1, 5'd0, 3'd0, x, 7'h13};
      4:       return {7'd0, 5'd6, 5'd0, 3'b010, x, 7'h23};
      default: return 32'd0;
    endcase
  endfunction

  localparam logic [31:0] BEQ  = 32'h00208063;
  localparam logic [31:0] BNE  = 32'h00209063;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADD5 = 32'h00100293;
  localparam logic [31:0] JLR5 = 32'h00028067;
  localparam logic [31:0] SW5  = 32'h006022A3;

  initial begin
    tbl.push_back(mk(1,0,32'h40,NOP,NOP,0, 0,3'd2,0,0,0,0));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd2,0,0,0,0));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,1, 1,3'd1,0,1,0,0));
    tbl.push_back(mk(0,0,32'h40,BEQ,BEQ,1, 1,3'd3,1,0,1,1));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,1, 1,3'd2,0,0,1,1));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd3,1,0,2,1));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,1, 1,3'd2,0,0,2,1));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd3,1,0,3,1));
    tbl.push_back(mk(0,0,32'h44,BNE,BEQ,0, 1,3'd4,0,1,3,1));
    tbl.push_back(mk(0,0,32'h48,NOP,BNE,0, 1,3'd2,0,0,4,2));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd3,1,0,4,2));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,0, 1,3'd4,0,1,4,2));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd2,0,0,5,3));
    tbl.push_back(mk(0,0,32'h80,JLR5,ADD5,0, 1,3'd0,0,0,5,3));
    tbl.push_back(mk(0,0,32'h80,JLR5,NOP,0, 1,3'd2,0,0,5,3));
    tbl.push_back(mk(0,0,32'h80,JLR5,SW5,0, 1,3'd2,0,0,5,3));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd2,0,0,5,3));
    tbl.push_back(mk(0,1,32'h44,NOP,BEQ,1, 1,3'd0,0,1,5,3));
    tbl.push_back(mk(0,1,32'h44,NOP,BEQ,1, 1,3'd0,0,1,5,3));
    tbl.push_back(mk(0,1,32'h44,NOP,BEQ,1, 1,3'd0,0,1,5,3));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,1, 1,3'd1,0,1,5,3));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,1, 1,3'd2,0,0,6,4));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd3,1,0,6,4));
    tbl.push_back(mk(1,0,32'h44,NOP,BEQ,1, 0,3'd2,0,0,0,0));
    tbl.push_back(mk(0,0,32'h40,BEQ,NOP,0, 1,3'd2,0,0,0,0));
    tbl.push_back(mk(0,0,32'h44,NOP,BEQ,0, 1,3'd2,0,0,0,0));
    tbl.push_back(mk(0,0,32'h48,NOP,NOP,0, 1,3'd2,0,0,1,0));

    rst = 1'b1; stall = 1'b0; pc = 32'h0; fi = NOP; ei = NOP;
    eq = 1'b0; lt = 1'b0;
    model_clock();
    @(posedge clk); #1;

    foreach (tbl[n]) begin
      rst = tbl[n].rst; stall = tbl[n].stall; pc = tbl[n].pc;
      fi = tbl[n].fi; ei = tbl[n].ei; eq = tbl[n].eq; lt = tbl[n].lt;
      #2;
      if (tbl[n].chk) begin
        check($sformatf("pcsel_t%0d", n), 32'(pcs0), 32'(tbl[n].pcs));
        check($sformatf("pred_t%0d", n), 32'(pred0), 32'(tbl[n].pred));
        check($sformatf("misp_t%0d", n), 32'(misp0), 32'(tbl[n].misp));
        check($sformatf("bcnt_t%0d", n), bc0, 32'(tbl[n].bc));
        check($sformatf("mcnt_t%0d", n), mc0, 32'(tbl[n].mc));
      end
      if (!rst) check_model(1);
      model_clock();
      @(posedge clk); #1;
    end

    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 7) == 0);
      pc    = 32'(($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8));
      fi    = rnd_inst();
      ei    = rnd_inst();
      eq    = 1'($urandom_range(0, 1));
      lt    = 1'($urandom_range(0, 1));
      #2;
      if (!rst) begin
        check_model(0);
        check_model(1);
      end
      model_clock();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/branch_predict_pcsel.md
Name: branch_predict_pcsel

Overview:
- Parametrised successor to the fetch-stage PC-select logic of the 3-stage RV32I pipeline.
- Adds a direct-mapped branch history table (BHT) of saturating counters to predict conditional branches at fetch.
- Resolves each branch one cycle later in execute using BrEq/BrLT.
- Drives a 3-bit PC-mux select, and handles misprediction recovery, JALR-after-writer hold and performance counters.

Parameters:
- INDEX_BITS, 6, log2 of BHT entries; index = fetch_pc[INDEX_BITS+1:2].
- COUNTER_BITS, 2, width of each saturating counter (>=1).
- PREDICT_EN, 1, 0 = always predict not-taken (legacy behaviour); table still trains.
- PERF_BITS, 32, width of the branch and mispredict counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  pipeline stall; freezes all state
- fetch_pc  input  32  PC of the instruction in fetch
- icache_dout  input  32  instruction in fetch
- ex_inst  input  32  instruction in execute
- BrEq  input  1  execute comparator: rs1 == rs2
- BrLT  input  1  execute comparator: rs1 < rs2 (signedness set by funct3 upstream)
- PCSignal  output  3  000 hold, 001 ALU target, 010 fetch_pc+4, 011 fetch_pc+B-imm, 100 ex_pc+4
- pred_taken  output  1  combinational prediction for the fetch instruction
- mispredict  output  1  combinational; execute branch outcome differs from its prediction
- branch_count  output  PERF_BITS  resolved branches
- mispredict_count  output  PERF_BITS  mispredictions

Behaviour:
- BHT: 2^INDEX_BITS entries, each COUNTER_BITS wide, held in flops.
  - On rst, all entries = 2^(COUNTER_BITS-1)-1 (weakly not-taken) in a single cycle.
- Prediction (combinational):
  - pred_taken = PREDICT_EN && fetch opcode == BRANCH && funct3 valid && MSB of BHT[fetch index].
  - Valid funct3 values: 000, 001, 100, 101, 110, 111.
- Execute-side registers ex_valid, ex_pred, ex_index.
  - On a non-stall cycle they capture 1, pred_taken, and the fetch index.
  - On a mispredict cycle they capture ex_valid=0, ex_pred=0 (squash).
  - Reset value of all three: 0.
- Resolution:
  - ex_branch = ex_valid && ex_inst opcode == BRANCH && funct3 valid.
  - actual: BEQ = BrEq; BNE = !BrEq; BLT/BLTU = BrLT; BGE/BGEU = !BrLT.
  - mispredict = ex_branch && (actual != ex_pred).
- Training: on ex_branch && !stall, BHT[ex_index] increments if taken, decrements if not.
  - Saturates at 2^COUNTER_BITS-1 and at 0.
  - Same-cycle read and write of one index: the prediction uses the pre-update value (no bypass).
- PCSignal priority (first match wins):
  1. stall -> 000.
  2. mispredict && actual -> 001.
  3. mispredict && !actual -> 100.
  4. JALR hold -> 000. JALR hold: fetch opcode JALR, ex_valid, ex_inst rd == fetch rs1, rd != 0, and ex opcode not BRANCH/STORE/NOOP.
  5. pred_taken -> 011.
  6. Otherwise -> 010.
- A correct prediction in execute produces no redirect.
- Perf counters (reset to 0, frozen on stall, wrap modulo 2^PERF_BITS):
  - branch_count increments on each ex_branch.
  - mispredict_count increments on each mispredict.
- Reset mid-operation: all state returns to reset values on the next edge. Outputs in the reset cycle follow the combinational rules with the reset register values, so PCSignal = 010 unless the fetch instruction is predicted taken.
- Latency:
  - Prediction: 0 cycles.
  - Resolution: 1 cycle after fetch.
  - Training is visible to a fetch of the same index 1 cycle after resolution.

Test Plan:
- Reset, fetch BEQ at pc 0x40 -> pred_taken=0, PCSignal=010. Next cycle with BrEq=1 -> mispredict=1, PCSignal=001, BHT[16] = 2, mispredict_count=1.
- Same BEQ resolves taken twice more -> BHT[16] saturates at 3. Next fetch at 0x40 -> pred_taken=1, PCSignal=011. Resolve with BrEq=0 -> PCSignal=100, BHT[16] = 2.
- Mispredict cycle: the instruction in fetch is a branch at 0x44 -> it is squashed. The following cycle mispredict=0 and branch_count does not increment.
- ex_inst = addi x5 (rd=5); fetch = jalr x0,0(x5) -> PCSignal=000. Repeat with rd=0 -> PCSignal=010. Repeat with ex = sw -> PCSignal=010.
- stall=1 for 3 cycles while a mispredicting branch sits in execute -> PCSignal=000, no BHT or counter change. On release -> redirect once, counters +1.
- PREDICT_EN=0: a fully trained taken branch -> pred_taken=0 and every taken resolution gives PCSignal=001. Assert rst mid-sequence -> all counters 0 and BHT entries = 1.
